// File: rtl/riscv_alu_src_ctrl_pkg.sv
// Shared ALU operand-source codes, RV32 opcodes, controller FSM states and the decode record.
package riscv_alu_src_ctrl_pkg;

  typedef enum logic [2:0] {
    SRC_REG     = 3'd0,
    SRC_IMM     = 3'd1,
    SRC_SHAMT   = 3'd2,
    SRC_PC      = 3'd3,
    SRC_PC_NEXT = 3'd4,
    SRC_CSR     = 3'd5,
    SRC_NULL    = 3'd6
  } alu_src_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

  // Selects for both beats; a1/b1 only matter when two_beat is set.
  typedef struct packed {
    alu_src_e src_a0;
    alu_src_e src_b0;
    alu_src_e src_a1;
    alu_src_e src_b1;
    logic     two_beat;
    logic     illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{SRC_NULL, SRC_NULL, SRC_NULL, SRC_NULL, 1'b0, 1'b0};

endpackage

// File: rtl/riscv_alu_src_ctrl_decode.sv
// Combinational opcode/funct3 -> operand-select decode for both execute beats.
// Zero latency; no handshake, the caller registers the result on accept.
module riscv_alu_src_decode
  import riscv_alu_src_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output dec_t       dec
);

  always_comb begin
    dec = DEC_RESET;
    unique case (opcode)
      OPC_OP, OPC_BRANCH: begin
        dec.src_a0 = SRC_REG;
        dec.src_b0 = SRC_REG;
      end
      OPC_OP_IMM: begin
        dec.src_a0 = SRC_REG;
        dec.src_b0 = (funct3 == 3'b001 || funct3 == 3'b101) ? SRC_SHAMT : SRC_IMM;
      end
      OPC_LOAD, OPC_STORE: begin
        dec.src_a0 = SRC_REG;
        dec.src_b0 = SRC_IMM;
      end
      OPC_LUI: begin
        dec.src_a0 = SRC_NULL;
        dec.src_b0 = SRC_IMM;
      end
      OPC_AUIPC: begin
        dec.src_a0 = SRC_PC;
        dec.src_b0 = SRC_IMM;
      end
      OPC_JAL, OPC_JALR: begin
        dec.src_a0 = SRC_PC_NEXT;
        dec.src_b0 = SRC_NULL;
      end
      OPC_SYSTEM: begin
        if (funct3 != 3'b000) begin
          // CSR read then modify: rs1 or zimm feeds the second beat.
          dec.two_beat = 1'b1;
          dec.src_a0   = SRC_CSR;
          dec.src_b0   = SRC_NULL;
          dec.src_a1   = SRC_CSR;
          dec.src_b1   = funct3[2] ? SRC_IMM : SRC_REG;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_alu_src_ctrl.sv
// Decode-to-execute operand-select stage; out_valid one cycle after accept, CSR ops take two beats.
// Backpressure: outputs hold while out_ready is low; in_ready combinationally follows out_ready on the last beat.
module riscv_alu_src_ctrl
  import riscv_alu_src_ctrl_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_src_a,
  output logic [2:0]      out_src_b,
  output logic            out_beat,
  output logic            out_last,
  output logic            out_illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] instr_q, pc_q;
  dec_t            dec_q, dec_d;
  logic            accept;

  riscv_alu_src_decode u_decode (
    .opcode (in_instr[6:0]),
    .funct3 (in_instr[14:12]),
    .dec    (dec_d)
  );

  assign out_valid   = (state_q != ST_EMPTY);
  assign out_beat    = (state_q == ST_BEAT1);
  assign out_last    = (state_q == ST_BEAT1) || (state_q == ST_BEAT0 && !dec_q.two_beat);
  assign out_illegal = dec_q.illegal;
  assign out_src_a   = out_beat ? dec_q.src_a1 : dec_q.src_a0;
  assign out_src_b   = out_beat ? dec_q.src_b1 : dec_q.src_b0;
  assign out_instr   = instr_q;
  assign out_pc      = pc_q;

  // A redirect kills the held beat and refuses any new instruction that cycle.
  assign in_ready = !flush && ((state_q == ST_EMPTY) || (out_ready && out_last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) state_d = ST_BEAT0;
        ST_BEAT0: begin
          if (out_ready) begin
            if (dec_q.two_beat) state_d = ST_BEAT1;
            else if (accept)    state_d = ST_BEAT0;
            else                state_d = ST_EMPTY;
          end
        end
        ST_BEAT1: if (out_ready) state_d = accept ? ST_BEAT0 : ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      dec_q   <= DEC_RESET;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= in_instr;
        pc_q    <= in_pc;
        dec_q   <= dec_d;
      end
    end
  end

endmodule

// File: tb/tb_riscv_alu_src_ctrl.sv
// Directed bench for riscv_alu_src_ctrl with a beat scoreboard fed by the stimulus sequence.
module tb_riscv_alu_src_ctrl;
  import riscv_alu_src_ctrl_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] in_instr, in_pc, out_instr, out_pc;
  logic [2:0]      out_src_a, out_src_b;
  logic            out_beat, out_last, out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        beat;
    logic        last;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  exp_t mon_o, mon_e;

  always #5 clk = ~clk;

  riscv_alu_src_ctrl #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_src_a   (out_src_a),
    .out_src_b   (out_src_b),
    .out_beat    (out_beat),
    .out_last    (out_last),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] a,
                      input logic [2:0] b, input logic beat, input logic last, input logic ill);
    sb.push_back('{instr, pc, a, b, beat, last, ill});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_src_a"}, out_src_a, 3'd6);
    chk({tag, "_src_b"}, out_src_b, 3'd6);
    chk({tag, "_instr"}, out_instr, 32'h0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_beat"}, out_beat, 1'b0);
    chk({tag, "_last"}, out_last, 1'b0);
    chk({tag, "_illegal"}, out_illegal, 1'b0);
  endtask

  // Every beat consumed (and not killed by flush) must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      mon_o = '{out_instr, out_pc, out_src_a, out_src_b, out_beat, out_last, out_illegal};
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_beat: observed %h expected none", mon_o);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checks++;
        assert (mon_o === mon_e) else begin
          errors++;
          $error("FAIL beat: observed %h expected %h", mon_o, mon_e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // addi x1,x2,5
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00510093; in_pc = 32'h100;
    push(32'h00510093, 32'h100, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_last", out_last, 1'b1);
    tick();

    // slli, auipc, jal back to back
    in_valid = 1'b1; in_instr = 32'h00311093; in_pc = 32'h104;
    push(32'h00311093, 32'h104, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    in_instr = 32'h00000097; in_pc = 32'h108;
    push(32'h00000097, 32'h108, 3'd3, 3'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_in_ready_auipc", in_ready, 1'b1);
    tick();
    in_instr = 32'h0000006F; in_pc = 32'h10C;
    push(32'h0000006F, 32'h10C, 3'd4, 3'd6, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_in_ready_jal", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_in_ready_tail", in_ready, 1'b1);
    tick();

    // csrrw then csrrwi reloaded on the csrrw second beat
    in_valid = 1'b1; in_instr = 32'h300110F3; in_pc = 32'h200;
    push(32'h300110F3, 32'h200, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0);
    push(32'h300110F3, 32'h200, 3'd5, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("csr_beat0_in_ready", in_ready, 1'b0);
    chk("csr_beat0_beat", out_beat, 1'b0);
    tick();
    @(negedge clk);
    chk("csr_beat1_beat", out_beat, 1'b1);
    in_valid = 1'b1; in_instr = 32'h300150F3; in_pc = 32'h204;
    push(32'h300150F3, 32'h204, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0);
    push(32'h300150F3, 32'h204, 3'd5, 3'd1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("csr_beat1_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    // lw stalled three cycles while an add waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00012083; in_pc = 32'h300;
    push(32'h00012083, 32'h300, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0);
    tick();
    in_instr = 32'h002081B3; in_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_instr", out_instr, 32'h00012083);
      chk("stall_pc", out_pc, 32'h300);
      chk("stall_srcs", {out_src_a, out_src_b}, {3'd0, 3'd1});
      chk("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    push(32'h002081B3, 32'h304, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_add_loaded", out_instr, 32'h002081B3);
    tick();

    // flush on CSR second beat with a competing offer
    in_valid = 1'b1; in_instr = 32'h300110F3; in_pc = 32'h400;
    push(32'h300110F3, 32'h400, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00510093; in_pc = 32'h404;
    @(negedge clk);
    chk("flush_beat1_state", out_beat, 1'b1);
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_empty_in_ready", in_ready, 1'b1);
    tick();

    // illegal opcode
    in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h500;
    push(32'h0000007F, 32'h500, 3'd6, 3'd6, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_flag", out_illegal, 1'b1);
    chk("illegal_last", out_last, 1'b1);
    tick();
    @(negedge clk);
    chk("illegal_single_beat", out_valid, 1'b0);

    // async reset while a beat is held
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1; in_instr = 32'h00012083; in_pc = 32'h600;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // recovery after reset
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00000097; in_pc = 32'h700;
    push(32'h00000097, 32'h700, 3'd3, 3'd1, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
